// File: rtl/mem_master.sv
// mem_master: burst initiator driving a single-port word memory (async read, falling-edge write)
module mem_master #(
  parameter int BITS_DATA = 32,
  parameter int BITS_ADDR = 16,
  parameter int BITS_LEN  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [BITS_ADDR-1:0] req_addr,
  input  logic [BITS_LEN-1:0]  req_len,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [BITS_DATA-1:0] wr_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BITS_DATA-1:0] rsp_data,
  output logic                 rsp_last,
  output logic                 done,
  output logic [BITS_ADDR-1:0] mem_address,
  output logic                 mem_write,
  output logic [BITS_DATA-1:0] mem_data_in,
  input  logic [BITS_DATA-1:0] mem_data_out
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [BITS_LEN-1:0]  cnt_q, cnt_d;
  logic [BITS_ADDR-1:0] ptr_q, ptr_d;
  logic [BITS_ADDR-1:0] mem_address_q, mem_address_d;
  logic [BITS_DATA-1:0] mem_data_in_q, mem_data_in_d;
  logic                 mem_write_q, mem_write_d;
  logic                 done_q, done_d;

  assign req_ready   = state_q == IDLE;
  assign rsp_valid   = state_q == RD;
  assign wr_ready    = state_q == WR;
  assign rsp_last    = (state_q == RD) && (cnt_q == '0);
  assign rsp_data    = mem_data_out;
  assign done        = done_q;
  assign mem_address = mem_address_q;
  assign mem_write   = mem_write_q;
  assign mem_data_in = mem_data_in_q;

  // next-state: accept requests, step read address on consume, register one write per accepted beat
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ptr_d         = ptr_q;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    mem_write_d   = 1'b0;
    done_d        = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        cnt_d = req_len;
        if (req_write) begin
          ptr_d   = req_addr;
          state_d = WR;
        end else begin
          mem_address_d = req_addr;
          state_d       = RD;
        end
      end
      RD: if (rsp_ready) begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          mem_address_d = mem_address_q + BITS_ADDR'(1);
          cnt_d         = cnt_q - BITS_LEN'(1);
        end
      end
      WR: if (wr_valid) begin
        mem_address_d = ptr_q;
        mem_data_in_d = wr_data;
        mem_write_d   = 1'b1;
        ptr_d         = ptr_q + BITS_ADDR'(1);
        cnt_d         = cnt_q - BITS_LEN'(1);
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state registers; async reset drops mem_write at once so no write lands after assertion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ptr_q         <= '0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      mem_write_q   <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ptr_q         <= ptr_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      mem_write_q   <= mem_write_d;
      done_q        <= done_d;
    end
  end
endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: scoreboard bench for mem_master with a word memory model and reference memory
module tb_mem_master;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        req_valid = 0, req_ready, req_write = 0;
  logic [15:0] req_addr = 0;
  logic [3:0]  req_len = 0;
  logic        wr_valid = 0, wr_ready;
  logic [31:0] wr_data = 0;
  logic        rsp_valid, rsp_ready = 0, rsp_last, done;
  logic [31:0] rsp_data;
  logic [15:0] mem_address;
  logic        mem_write;
  logic [31:0] mem_data_in, mem_data_out;

  logic [31:0] mem [0:65535];
  logic [31:0] ref_mem [0:65535];
  logic [47:0] wq[$];
  logic [32:0] rq[$];
  logic [15:0] waddr;
  int total = 0, bad = 0;

  mem_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .done(done),
    .mem_address(mem_address), .mem_write(mem_write),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  assign mem_data_out = mem[mem_address];
  always @(negedge clk) if (mem_write) mem[mem_address] <= mem_data_in;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // write monitor: every falling-edge write must match the next accepted beat
  always @(negedge clk) if (rst_n && mem_write) begin
    chk("write_in_rd", rsp_valid, 0);
    if (wq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_write: addr %0h data %0h", mem_address, mem_data_in);
    end else begin
      logic [47:0] e;
      e = wq.pop_front();
      chk("write_addr", mem_address, e[47:32]);
      chk("write_data", mem_data_in, e[31:0]);
    end
  end

  // read monitor: each consumed beat must match the reference memory snapshot
  always @(negedge clk) if (rst_n && rsp_valid && rsp_ready) begin
    if (rq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_beat: data %0h", rsp_data);
    end else begin
      logic [32:0] e;
      e = rq.pop_front();
      chk("rsp_data", rsp_data, e[31:0]);
      chk("rsp_last", rsp_last, e[32]);
    end
  end

  task automatic do_req(input logic w, input logic [15:0] a, input logic [3:0] l);
    int n = 0;
    req_valid = 1; req_write = w; req_addr = a; req_len = l;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("req_ready_wait", n < 50, 1);
    @(posedge clk); #1;
    req_valid = 0; req_write = $urandom; req_len = 4'($urandom); req_addr = 16'($urandom);
  endtask

  task automatic wr_beat(input logic [31:0] d, input int gap, input logic last);
    int n = 0;
    wr_valid = 0;
    repeat (gap) begin @(posedge clk); #1; chk("gap_mem_write", mem_write, 0); end
    wr_valid = 1; wr_data = d;
    while (!wr_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("wr_ready_wait", n < 50, 1);
    wq.push_back({waddr, d});
    ref_mem[waddr] = d;
    waddr = waddr + 16'd1;
    @(posedge clk); #1;
    wr_valid = 0; wr_data = $urandom;
    chk("beat_mem_write", mem_write, 1);
    chk("done", done, last);
  endtask

  task automatic do_write(input logic [15:0] a, input int len, input int gap, input logic [31:0] base, input logic rnd);
    do_req(1, a, 4'(len));
    waddr = a;
    for (int i = 0; i <= len; i++)
      wr_beat(base == 0 ? $urandom : base + 32'(i), rnd ? int'($urandom_range(0, 2)) : (i == 0 ? 0 : gap), i == len);
  endtask

  task automatic rd_burst(input logic [15:0] a, input int len, input int sb, input int sn, input logic rnd);
    logic [15:0] ea;
    logic [31:0] hd;
    for (int i = 0; i <= len; i++) begin
      ea = a + 16'(i);
      rq.push_back({i == len, ref_mem[ea]});
    end
    do_req(0, a, 4'(len));
    chk("rd_latency", rsp_valid, 1);
    for (int i = 0; i <= len; i++) begin
      int s = (i == sb) ? sn : (rnd ? int'($urandom_range(0, 2)) : 0);
      ea = a + 16'(i);
      rsp_ready = 0;
      chk("rd_addr", mem_address, ea);
      hd = rsp_data;
      repeat (s) begin
        @(posedge clk); #1;
        chk("stall_valid", rsp_valid, 1);
        chk("stall_addr", mem_address, ea);
        chk("stall_data", rsp_data, hd);
        chk("stall_last", rsp_last, i == len);
      end
      rsp_ready = 1;
      @(posedge clk); #1;
    end
    rsp_ready = 0;
    chk("rd_beats_left", rq.size(), 0);
    chk("rd_idle", req_ready, 1);
    chk("rd_valid_off", rsp_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: total=%0d", total);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = (i == 0) ? 32'h0900000D : 32'h9E3779B9 * 32'(i);
      ref_mem[i] = mem[i];
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_outs", {wr_ready, rsp_valid, rsp_last, done, mem_write}, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_din", mem_data_in, 0);
    rst_n = 1;
    @(posedge clk); #1;
    rd_burst(16'h0000, 0, -1, 0, 0);
    do_write(16'h0010, 0, 0, 32'hDEADBEEF, 0);
    rd_burst(16'h0010, 0, -1, 0, 0);
    do_write(16'hFFFE, 3, 0, 32'd1, 0);
    rd_burst(16'hFFFE, 3, -1, 0, 0);
    chk("wrap_mem0", mem[0], 32'd3);
    chk("wrap_mem1", mem[1], 32'd4);
    rd_burst(16'h0040, 2, 1, 3, 0);
    do_write(16'h0100, 3, 2, 32'h100, 0);
    rd_burst(16'h0100, 3, -1, 0, 0);
    do_req(1, 16'h0200, 4'd7);
    waddr = 16'h0200;
    wr_beat(32'hA1, 0, 0);
    wr_beat(32'hA2, 0, 0);
    @(negedge clk); #1;
    wr_valid = 1; wr_data = 32'hBAD;
    rst_n = 0;
    #1;
    chk("rst_mid_write", mem_write, 0);
    chk("rst_mid_wr_ready", wr_ready, 0);
    chk("rst_mid_req_ready", req_ready, 1);
    chk("rst_mid_addr", mem_address, 0);
    repeat (2) @(posedge clk);
    #1;
    wr_valid = 0;
    rst_n = 1;
    @(posedge clk); #1;
    chk("post_rst_req_ready", req_ready, 1);
    chk("post_rst_wr_ready", wr_ready, 0);
    chk("post_rst_wq", wq.size(), 0);
    for (int i = 0; i < 8; i++) chk("rst_region", mem[16'h0200 + i], ref_mem[16'h0200 + i]);
    for (int k = 0; k < 30; k++) begin
      logic [15:0] a = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15)) : 16'($urandom_range(0, 255));
      int l = $urandom_range(0, 15);
      if ($urandom_range(0, 1)) do_write(a, l, 0, 0, 1);
      else rd_burst(a, l, -1, 0, 1);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("final_wq", wq.size(), 0);
    chk("final_rq", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
